// File: rtl/cajero_automatico_ctrl_pkg.sv
// Shared types and widths for the ATM transaction controller.
package cajero_pkg;

    localparam int unsigned N_DIGITOS = 4;
    localparam int unsigned DIG_W     = 4;
    localparam int unsigned PIN_W     = DIG_W * N_DIGITOS;
    localparam int unsigned BAL_W     = 64;
    localparam int unsigned MONTO_W   = 32;

    localparam logic TIPO_DEPOSITO = 1'b0;
    localparam logic TIPO_RETIRO   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        PIN,
        VERIF,
        TRANS,
        BLOQUEO
    } estado_t;

endpackage

// File: rtl/cajero_automatico_ctrl_if.sv
// Front-end / datapath signal bundle of the ATM controller.
interface cajero_automatico_ctrl_if;
    import cajero_pkg::*;

    logic                tarjeta_recibida;
    logic                digito_stb;
    logic [DIG_W-1:0]    digito;
    logic [PIN_W-1:0]    pin_correcto;
    logic                tipo_trans;
    logic [MONTO_W-1:0]  monto;
    logic [BAL_W-1:0]    balance_inicial;

    logic                pin_incorrecto;
    logic                advertencia;
    logic                bloqueo;
    logic [BAL_W-1:0]    balance_actualizado;
    logic                balance_stb;
    logic                entregar_dinero;
    logic                fondos_insuficientes;

    modport master (
        output tarjeta_recibida, digito_stb, digito, pin_correcto,
               tipo_trans, monto, balance_inicial,
        input  pin_incorrecto, advertencia, bloqueo, balance_actualizado,
               balance_stb, entregar_dinero, fondos_insuficientes
    );

    modport slave (
        input  tarjeta_recibida, digito_stb, digito, pin_correcto,
               tipo_trans, monto, balance_inicial,
        output pin_incorrecto, advertencia, bloqueo, balance_actualizado,
               balance_stb, entregar_dinero, fondos_insuficientes
    );

endinterface

// File: rtl/cajero_automatico_ctrl_captura_pin.sv
// PIN digit shift register and digit counter; done_c flags the last accepted digit.
module captura_pin
    import cajero_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [DIG_W-1:0] digito,
    output logic [PIN_W-1:0] pin_reg,
    output logic             done_c
);

    localparam int unsigned CNT_W = $clog2(N_DIGITOS + 1);

    logic [PIN_W-1:0] pin_d, pin_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pin_q <= '0;
            cnt_q <= '0;
        end else begin
            pin_q <= pin_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        pin_d  = pin_q;
        cnt_d  = cnt_q;
        done_c = 1'b0;
        if (clr) begin
            pin_d = '0;
            cnt_d = '0;
        end else if (en) begin
            pin_d  = {pin_q[PIN_W-DIG_W-1:0], digito};
            cnt_d  = CNT_W'(cnt_q + CNT_W'(1));
            done_c = (cnt_q == CNT_W'(N_DIGITOS - 1));
        end
    end

    assign pin_reg = pin_q;

endmodule

// File: rtl/cajero_automatico_ctrl.sv
// ATM session controller: card, PIN check with attempt lockout, one deposit/withdrawal.
module cajero_automatico_ctrl
    import cajero_pkg::*;
#(
    parameter int unsigned MAX_INTENTOS = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    cajero_automatico_ctrl_if.slave  bus
);

    localparam int unsigned INT_W = $clog2(MAX_INTENTOS + 1);

    estado_t          state_d, state_q;
    logic [INT_W-1:0] intentos_d, intentos_q, intentos_inc;
    logic             pin_inc_d, pin_inc_q;
    logic             adv_d, adv_q;
    logic             bloq_d, bloq_q;
    logic [BAL_W-1:0] bal_d, bal_q;
    logic             stb_d, stb_q;
    logic             ent_d, ent_q;
    logic             fondos_d, fondos_q;

    logic             clr_c, en_c, done_c;
    logic [PIN_W-1:0] pin_reg;
    logic [BAL_W-1:0] monto_ext;

    captura_pin u_captura_pin (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr_c),
        .en      (en_c),
        .digito  (bus.digito),
        .pin_reg (pin_reg),
        .done_c  (done_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            intentos_q <= '0;
            pin_inc_q  <= 1'b0;
            adv_q      <= 1'b0;
            bloq_q     <= 1'b0;
            bal_q      <= '0;
            stb_q      <= 1'b0;
            ent_q      <= 1'b0;
            fondos_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            intentos_q <= intentos_d;
            pin_inc_q  <= pin_inc_d;
            adv_q      <= adv_d;
            bloq_q     <= bloq_d;
            bal_q      <= bal_d;
            stb_q      <= stb_d;
            ent_q      <= ent_d;
            fondos_q   <= fondos_d;
        end
    end

    assign monto_ext    = BAL_W'(bus.monto);
    assign intentos_inc = INT_W'(intentos_q + INT_W'(1));

    always_comb begin
        state_d    = state_q;
        intentos_d = intentos_q;
        pin_inc_d  = 1'b0;
        adv_d      = adv_q;
        bloq_d     = bloq_q;
        bal_d      = bal_q;
        stb_d      = 1'b0;
        ent_d      = 1'b0;
        fondos_d   = 1'b0;
        clr_c      = 1'b0;
        en_c       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.tarjeta_recibida) begin
                    state_d    = PIN;
                    clr_c      = 1'b1;
                    intentos_d = '0;
                    adv_d      = 1'b0;
                end
            end
            PIN: begin
                en_c = bus.digito_stb;
                if (done_c) state_d = VERIF;
            end
            VERIF: begin
                if (pin_reg == bus.pin_correcto) begin
                    intentos_d = '0;
                    adv_d      = 1'b0;
                    state_d    = TRANS;
                end else begin
                    intentos_d = intentos_inc;
                    pin_inc_d  = 1'b1;
                    clr_c      = 1'b1;
                    if (intentos_inc >= INT_W'(MAX_INTENTOS)) begin
                        bloq_d  = 1'b1;
                        state_d = BLOQUEO;
                    end else begin
                        if (intentos_inc >= INT_W'(MAX_INTENTOS - 1)) adv_d = 1'b1;
                        state_d = PIN;
                    end
                end
            end
            TRANS: begin
                state_d = IDLE;
                if (bus.tipo_trans == TIPO_DEPOSITO) begin
                    bal_d = bus.balance_inicial + monto_ext;
                    stb_d = 1'b1;
                end else if (monto_ext <= bus.balance_inicial) begin
                    bal_d = bus.balance_inicial - monto_ext;
                    stb_d = 1'b1;
                    ent_d = 1'b1;
                end else begin
                    fondos_d = 1'b1;
                end
            end
            BLOQUEO: begin
                bloq_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.pin_incorrecto       = pin_inc_q;
    assign bus.advertencia          = adv_q;
    assign bus.bloqueo              = bloq_q;
    assign bus.balance_actualizado  = bal_q;
    assign bus.balance_stb          = stb_q;
    assign bus.entregar_dinero      = ent_q;
    assign bus.fondos_insuficientes = fondos_q;

endmodule

// File: tb/tb_cajero_automatico_ctrl.sv
// Directed bench for cajero_automatico_ctrl: transaction table plus lockout/reset/recovery sequences.
module tb_cajero_automatico_ctrl;
    import cajero_pkg::*;

    logic clk;
    logic reset;

    cajero_automatico_ctrl_if bus ();

    cajero_automatico_ctrl #(.MAX_INTENTOS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        tipo;
        logic [31:0] monto;
        logic [63:0] bal_in;
        logic [63:0] exp_bal;
        logic        exp_stb;
        logic        exp_ent;
        logic        exp_fondos;
    } vec_t;

    vec_t vecs [8];
    int   n_vec;
    int   n_bad;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic card();
        bus.tarjeta_recibida = 1'b1;
        tick();
        bus.tarjeta_recibida = 1'b0;
    endtask

    // Four strobes; returns right after edge E (the 4th strobe).
    task automatic enter_pin(input logic [15:0] p);
        for (int i = 0; i < 4; i++) begin
            bus.digito_stb = 1'b1;
            bus.digito     = p[15-4*i -: 4];
            tick();
        end
        bus.digito_stb = 1'b0;
        bus.digito     = 4'd0;
    endtask

    task automatic wrong_pin(input string name, input logic exp_adv, input logic exp_bloq);
        enter_pin(16'h1111);
        tick();
        chk({name, "_pin_inc"}, 64'(bus.pin_incorrecto), 64'(1'b1));
        chk({name, "_adv"},     64'(bus.advertencia), 64'(exp_adv));
        chk({name, "_bloq"},    64'(bus.bloqueo), 64'(exp_bloq));
        tick();
        chk({name, "_pin_inc_drop"}, 64'(bus.pin_incorrecto), 64'(1'b0));
    endtask

    task automatic run_session(input string name, input logic tipo, input logic [31:0] monto,
                               input logic [63:0] bal_in, input logic [63:0] exp_bal,
                               input logic exp_stb, input logic exp_ent, input logic exp_fondos);
        card();
        enter_pin(16'h1234);
        bus.tipo_trans      = tipo;
        bus.monto           = monto;
        bus.balance_inicial = bal_in;
        tick();
        chk({name, "_verif"}, {61'd0, bus.pin_incorrecto, bus.advertencia, bus.bloqueo}, 64'd0);
        tick();
        chk({name, "_bal"}, bus.balance_actualizado, exp_bal);
        chk({name, "_pulses"},
            {61'd0, bus.balance_stb, bus.entregar_dinero, bus.fondos_insuficientes},
            {61'd0, exp_stb, exp_ent, exp_fondos});
        tick();
        chk({name, "_pulses_drop"},
            {61'd0, bus.balance_stb, bus.entregar_dinero, bus.fondos_insuficientes}, 64'd0);
        chk({name, "_bal_hold"}, bus.balance_actualizado, exp_bal);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_bal"}, bus.balance_actualizado, 64'd0);
        chk({name, "_flags"},
            {57'd0, bus.pin_incorrecto, bus.advertencia, bus.bloqueo, bus.balance_stb,
             bus.entregar_dinero, bus.fondos_insuficientes, 1'b0}, 64'd0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        vecs[0] = '{TIPO_DEPOSITO, 32'd500,        64'd1000,               64'd1500,               1'b1, 1'b0, 1'b0};
        vecs[1] = '{TIPO_RETIRO,   32'd300,        64'd1000,               64'd700,                1'b1, 1'b1, 1'b0};
        vecs[2] = '{TIPO_RETIRO,   32'd1000,       64'd1000,               64'd0,                  1'b1, 1'b1, 1'b0};
        vecs[3] = '{TIPO_RETIRO,   32'd2000,       64'd1000,               64'd0,                  1'b0, 1'b0, 1'b1};
        vecs[4] = '{TIPO_DEPOSITO, 32'd2,          64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 1'b1, 1'b0, 1'b0};
        vecs[5] = '{TIPO_RETIRO,   32'hFFFF_FFFF,  64'h1_0000_0000,        64'd1,                  1'b1, 1'b1, 1'b0};
        vecs[6] = '{TIPO_RETIRO,   32'd5,          64'd4,                  64'd1,                  1'b0, 1'b0, 1'b1};
        vecs[7] = '{TIPO_DEPOSITO, 32'd0,          64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, 1'b0};

        reset                = 1'b1;
        bus.tarjeta_recibida = 1'b0;
        bus.digito_stb       = 1'b0;
        bus.digito           = 4'd0;
        bus.pin_correcto     = 16'h1234;
        bus.tipo_trans       = 1'b0;
        bus.monto            = 32'd0;
        bus.balance_inicial  = 64'd0;
        tick();
        tick();
        chk_all_zero("reset_init");
        reset = 1'b0;
        tick();

        // Strobes while idle must not leak into the next PIN.
        bus.digito_stb = 1'b1;
        bus.digito     = 4'd9;
        tick();
        bus.digito_stb = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_session($sformatf("vec%0d", i), vecs[i].tipo, vecs[i].monto, vecs[i].bal_in,
                        vecs[i].exp_bal, vecs[i].exp_stb, vecs[i].exp_ent, vecs[i].exp_fondos);
        end

        // Reset in the middle of PIN entry with advertencia set and a nonzero balance.
        card();
        wrong_pin("mid_w1", 1'b0, 1'b0);
        wrong_pin("mid_w2", 1'b1, 1'b0);
        bus.digito_stb = 1'b1;
        bus.digito     = 4'd1;
        tick();
        bus.digito     = 4'd2;
        tick();
        bus.digito_stb = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("mid_reset_async");
        tick();
        chk_all_zero("mid_reset_held");
        reset = 1'b0;
        run_session("after_reset", TIPO_DEPOSITO, 32'd7, 64'd10, 64'd17, 1'b1, 1'b0, 1'b0);

        // Recovery: one wrong PIN then the correct one inside the same session.
        card();
        wrong_pin("rec_w1", 1'b0, 1'b0);
        enter_pin(16'h1234);
        bus.tipo_trans      = TIPO_DEPOSITO;
        bus.monto           = 32'd100;
        bus.balance_inicial = 64'd50;
        tick();
        chk("rec_verif", {61'd0, bus.pin_incorrecto, bus.advertencia, bus.bloqueo}, 64'd0);
        tick();
        chk("rec_bal", bus.balance_actualizado, 64'd150);
        chk("rec_stb", {62'd0, bus.balance_stb, bus.entregar_dinero}, 64'd2);

        // Lockout after three wrong entries.
        tick();
        card();
        wrong_pin("lk_w1", 1'b0, 1'b0);
        wrong_pin("lk_w2", 1'b1, 1'b0);
        wrong_pin("lk_w3", 1'b1, 1'b1);
        card();
        bus.tipo_trans      = TIPO_RETIRO;
        bus.monto           = 32'd1;
        bus.balance_inicial = 64'd1000;
        enter_pin(16'h1234);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("lk_hold%0d", i),
                {59'd0, bus.balance_stb, bus.entregar_dinero, bus.fondos_insuficientes,
                 bus.pin_incorrecto, bus.bloqueo}, 64'd1);
        end
        chk("lk_bal_hold", bus.balance_actualizado, 64'd150);
        chk("lk_adv_hold", 64'(bus.advertencia), 64'd1);

        reset = 1'b1;
        tick();
        chk_all_zero("lk_reset");
        reset = 1'b0;
        tick();
        run_session("post_lock", TIPO_RETIRO, 32'd250, 64'd1000, 64'd750, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
